// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data RAM arbiter.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2
   } rd_owner_e;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_LD  = 2'd1,
      OP_SD  = 2'd2
   } mem_op_e;

   function automatic mem_op_e decode_op(input logic req, input logic we);
      if (!req)   return OP_NOP;
      else if (we) return OP_SD;
      else        return OP_LD;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between the fetch and data ports, the arbiter and the RAM.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic              if_req;
   logic [63:0]       if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [63:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_misalign;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              stall_if;
   logic              stall_mem;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
             mem_misalign, ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
             mem_misalign, ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
   );

endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Counts consecutive data grants that held off a pending fetch; flags when fetch must win.
module arb_starve_counter #(
   parameter int unsigned LIMIT = 4
)(
   input  logic clk,
   input  logic rst_n,
   input  logic i_if_req,
   input  logic i_if_gnt,
   input  logic i_mem_gnt,
   output logic o_at_limit
);
   localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_if_gnt || !i_if_req) begin
         r_cnt <= '0;
      end else if (i_mem_gnt && (r_cnt != LIMIT_C)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_at_limit = (r_cnt == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses win over fetch unless fetch has been starved too long.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = 4
)(
   input  logic          clock,
   input  logic          reset_n,
   mem_arbiter_if.slave  bus
);
   mem_op_e           w_mem_op;
   logic              w_at_limit;
   logic              w_if_wins;
   logic              w_if_gnt;
   logic              w_mem_gnt;
   logic              w_mem_store;
   logic              w_mem_load;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] r_last_addr;
   logic [DATA_W-1:0] r_last_wdata;
   rd_owner_e         r_rd_owner;
   rd_owner_e         w_rd_owner_nxt;
   logic              w_unused_addr_bits;

   arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk        (clock),
      .rst_n      (reset_n),
      .i_if_req   (bus.if_req),
      .i_if_gnt   (w_if_gnt),
      .i_mem_gnt  (w_mem_gnt),
      .o_at_limit (w_at_limit)
   );

   // Grants are gated by reset_n so a request in the reset cycle cannot load rd_owner.
   always_comb begin
      w_mem_op    = decode_op(bus.mem_req, bus.mem_we);
      w_if_wins   = bus.if_req && (w_at_limit || (w_mem_op == OP_NOP));
      w_if_gnt    = reset_n && w_if_wins;
      w_mem_gnt   = reset_n && !w_if_wins && (w_mem_op != OP_NOP);
      w_mem_store = w_mem_gnt && (w_mem_op == OP_SD);
      w_mem_load  = w_mem_gnt && (w_mem_op == OP_LD);
      w_addr      = w_if_gnt ? bus.if_addr[ADDR_W+1:2] : bus.mem_addr[ADDR_W+1:2];
   end

   always_comb begin
      w_rd_owner_nxt = OWN_NONE;
      if (w_if_gnt)        w_rd_owner_nxt = OWN_IF;
      else if (w_mem_load) w_rd_owner_nxt = OWN_MEM;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_rd_owner <= OWN_NONE;
      else          r_rd_owner <= w_rd_owner_nxt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_last_addr  <= '0;
         r_last_wdata <= '0;
      end else begin
         if (w_if_gnt || w_mem_gnt) r_last_addr  <= w_addr;
         if (w_mem_store)           r_last_wdata <= bus.mem_wdata;
      end
   end

   assign bus.if_gnt       = w_if_gnt;
   assign bus.mem_gnt      = w_mem_gnt;
   assign bus.ram_en       = w_if_gnt || w_mem_gnt;
   assign bus.ram_we       = w_mem_store;
   assign bus.ram_addr     = (w_if_gnt || w_mem_gnt) ? w_addr : r_last_addr;
   assign bus.ram_wdata    = w_mem_store ? bus.mem_wdata : r_last_wdata;
   assign bus.if_rvalid    = (r_rd_owner == OWN_IF);
   assign bus.mem_rvalid   = (r_rd_owner == OWN_MEM);
   assign bus.if_rdata     = reset_n ? bus.ram_rdata : '0;
   assign bus.mem_rdata    = reset_n ? bus.ram_rdata : '0;
   assign bus.stall_if     = bus.if_req && !w_if_gnt;
   assign bus.stall_mem    = bus.mem_req && !w_mem_gnt;
   assign bus.mem_misalign = w_mem_gnt && (bus.mem_addr[1:0] != 2'b00);

   assign w_unused_addr_bits = ^{bus.if_addr[63:ADDR_W+2], bus.if_addr[1:0],
                                 bus.mem_addr[63:ADDR_W+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: read results are queued at grant time and checked on rvalid.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;

   logic clock;
   logic reset_n;
   int   n_vec;
   int   n_err;
   int   cyc;

   typedef struct {
      int          due;
      bit          is_if;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ram    [1024];
   logic [31:0] sb_mem [1024];
   logic [9:0]  last_addr;
   logic [31:0] last_wdata;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural single-port RAM with one cycle read latency.
   always @(posedge clock) begin
      if (bus.ram_en) begin
         if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= ram[bus.ram_addr];
      end
   end

   always @(negedge clock) begin : monitor
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         n_vec++;
         if (bus.if_rvalid !== e.is_if || bus.mem_rvalid !== !e.is_if) begin
            n_err++;
            $display("FAIL rvalid @%0d: if/mem got %b%b expected %b%b", cyc,
                     bus.if_rvalid, bus.mem_rvalid, e.is_if, !e.is_if);
         end
         n_vec++;
         if ((e.is_if ? bus.if_rdata : bus.mem_rdata) !== e.data) begin
            n_err++;
            $display("FAIL rdata @%0d: got %h expected %h", cyc,
                     e.is_if ? bus.if_rdata : bus.mem_rdata, e.data);
         end
      end else begin
         if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            n_err++;
            $display("FAIL stale_read @%0d: due %0d never completed", cyc, e.due);
         end
         n_vec++;
         if (bus.if_rvalid !== 1'b0 || bus.mem_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL spurious_rvalid @%0d: if/mem got %b%b expected 00", cyc,
                     bus.if_rvalid, bus.mem_rvalid);
         end
      end
   end

   task automatic drive(input logic ifr, input logic [63:0] ifa, input logic mr,
                        input logic mwe, input logic [63:0] ma, input logic [31:0] mwd);
      bus.if_req    = ifr;
      bus.if_addr   = ifa;
      bus.mem_req   = mr;
      bus.mem_we    = mwe;
      bus.mem_addr  = ma;
      bus.mem_wdata = mwd;
   endtask

   task automatic test_reset();
      drive(1'b1, 64'h8, 1'b1, 1'b1, 64'h13, 32'h1234_5678);
      #3;
      n_vec++;
      if ({bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we, bus.mem_misalign,
           bus.if_rvalid, bus.mem_rvalid} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b expected 0000000", {bus.if_gnt, bus.mem_gnt,
                  bus.ram_en, bus.ram_we, bus.mem_misalign, bus.if_rvalid, bus.mem_rvalid});
      end
      n_vec++;
      if (bus.ram_addr !== 10'd0 || bus.ram_wdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset_ram_bus: addr %h wdata %h expected 0", bus.ram_addr, bus.ram_wdata);
      end
      n_vec++;
      if (bus.if_rdata !== 32'd0 || bus.mem_rdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset_rdata: if %h mem %h expected 0", bus.if_rdata, bus.mem_rdata);
      end
      @(posedge clock);
      #2;
      drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
      reset_n = 1'b1;
   endtask

   task automatic test_idle(input string tag);
      @(negedge clock);
      drive(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
      #1;
      n_vec++;
      if (bus.ram_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.if_gnt !== 1'b0 || bus.mem_gnt !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ctrl(%s): en %b we %b gnt %b%b expected 0", tag,
                  bus.ram_en, bus.ram_we, bus.if_gnt, bus.mem_gnt);
      end
      n_vec++;
      if (bus.ram_addr !== last_addr || bus.ram_wdata !== last_wdata) begin
         n_err++;
         $display("FAIL idle_hold(%s): addr %h wdata %h expected %h %h", tag,
                  bus.ram_addr, bus.ram_wdata, last_addr, last_wdata);
      end
   endtask

   task automatic test_if_read();
      @(negedge clock);
      drive(1'b1, 64'h8, 1'b0, 1'b0, 64'h0, 32'h0);
      #1;
      n_vec++;
      if ({bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we, bus.stall_if} !== 5'b10100
          || bus.ram_addr !== 10'd2) begin
         n_err++;
         $display("FAIL if_read: gnt/en/we/stall %b addr %h expected 10100 addr 002",
                  {bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we, bus.stall_if}, bus.ram_addr);
      end
      exp_q.push_back('{due: cyc + 1, is_if: 1'b1, data: sb_mem[2]});
      last_addr = 10'd2;
   endtask

   task automatic test_priority();
      @(negedge clock);
      drive(1'b1, 64'h8, 1'b1, 1'b0, 64'h10, 32'h0);
      #1;
      n_vec++;
      if ({bus.if_gnt, bus.mem_gnt, bus.stall_if, bus.stall_mem} !== 4'b0110
          || bus.ram_addr !== 10'd4) begin
         n_err++;
         $display("FAIL priority: gnt/stall %b addr %h expected 0110 addr 004",
                  {bus.if_gnt, bus.mem_gnt, bus.stall_if, bus.stall_mem}, bus.ram_addr);
      end
      exp_q.push_back('{due: cyc + 1, is_if: 1'b0, data: sb_mem[4]});
      last_addr = 10'd4;
   endtask

   task automatic test_starvation();
      bit exp_if;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         drive(1'b1, 64'h80, 1'b1, 1'b0, 64'h40, 32'h0);
         #1;
         exp_if = (i == 4);
         n_vec++;
         if (bus.if_gnt !== exp_if || bus.mem_gnt !== !exp_if
             || bus.ram_addr !== (exp_if ? 10'd32 : 10'd16)) begin
            n_err++;
            $display("FAIL starve cycle %0d: gnt if/mem %b%b addr %h expected %b%b", i + 1,
                     bus.if_gnt, bus.mem_gnt, bus.ram_addr, exp_if, !exp_if);
         end
         exp_q.push_back('{due: cyc + 1, is_if: exp_if, data: sb_mem[exp_if ? 32 : 16]});
         last_addr = exp_if ? 10'd32 : 10'd16;
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clock);
      drive(1'b0, 64'h0, 1'b1, 1'b1, 64'h20, 32'h0000_00A5);
      #1;
      n_vec++;
      if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 10'd8
          || bus.ram_wdata !== 32'hA5) begin
         n_err++;
         $display("FAIL store: gnt %b we %b addr %h wdata %h expected 1 1 008 000000a5",
                  bus.mem_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      sb_mem[8]  = 32'hA5;
      last_addr  = 10'd8;
      last_wdata = 32'hA5;
      @(negedge clock);
      drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h20, 32'hFFFF_FFFF);
      #1;
      n_vec++;
      if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 10'd8
          || bus.ram_wdata !== 32'hA5) begin
         n_err++;
         $display("FAIL load_after_store: gnt %b we %b addr %h wdata %h expected 1 0 008 000000a5",
                  bus.mem_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      exp_q.push_back('{due: cyc + 1, is_if: 1'b0, data: sb_mem[8]});
   endtask

   task automatic test_misalign_wrap();
      @(negedge clock);
      drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h13, 32'h0);
      #1;
      n_vec++;
      if (bus.mem_misalign !== 1'b1 || bus.ram_addr !== 10'd4) begin
         n_err++;
         $display("FAIL misalign: flag %b addr %h expected 1 004", bus.mem_misalign, bus.ram_addr);
      end
      exp_q.push_back('{due: cyc + 1, is_if: 1'b0, data: sb_mem[4]});
      @(negedge clock);
      drive(1'b0, 64'h0, 1'b1, 1'b0, 64'h1000, 32'h0);
      #1;
      n_vec++;
      if (bus.mem_misalign !== 1'b0 || bus.ram_addr !== 10'd0) begin
         n_err++;
         $display("FAIL wrap: flag %b addr %h expected 0 000", bus.mem_misalign, bus.ram_addr);
      end
      exp_q.push_back('{due: cyc + 1, is_if: 1'b0, data: sb_mem[0]});
      last_addr = 10'd0;
   endtask

   task automatic test_reset_midread();
      bit exp_if;
      // Four held-off stores bring the starvation count to its limit.
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         drive(1'b1, 64'hC, 1'b1, 1'b1, 64'h100 + 64'(4 * i), 32'h1000 + 32'(i));
         #1;
         n_vec++;
         if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_store %0d: gnt %b we %b expected 1 1", i, bus.mem_gnt, bus.ram_we);
         end
         sb_mem[64 + i] = 32'h1000 + 32'(i);
      end
      @(negedge clock);
      #1;
      n_vec++;
      if (bus.if_gnt !== 1'b1 || bus.ram_addr !== 10'd3) begin
         n_err++;
         $display("FAIL starved_if: gnt %b addr %h expected 1 003", bus.if_gnt, bus.ram_addr);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we} !== 4'b0
          || bus.ram_addr !== 10'd0 || bus.ram_wdata !== 32'd0) begin
         n_err++;
         $display("FAIL async_reset: gnt/en/we %b addr %h wdata %h expected 0",
                  {bus.if_gnt, bus.mem_gnt, bus.ram_en, bus.ram_we}, bus.ram_addr, bus.ram_wdata);
      end
      @(posedge clock);
      #2;
      reset_n    = 1'b1;
      last_wdata = 32'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         drive(1'b1, 64'h18, 1'b1, 1'b1, 64'h200, 32'h5A5A_0000 + 32'(i));
         #1;
         exp_if = (i == 4);
         n_vec++;
         if (bus.if_gnt !== exp_if || bus.mem_gnt !== !exp_if) begin
            n_err++;
            $display("FAIL post_reset_starve %0d: gnt if/mem %b%b expected %b%b", i + 1,
                     bus.if_gnt, bus.mem_gnt, exp_if, !exp_if);
         end
         if (exp_if) begin
            exp_q.push_back('{due: cyc + 1, is_if: 1'b1, data: sb_mem[6]});
            last_addr = 10'd6;
         end else begin
            sb_mem[128] = 32'h5A5A_0000 + 32'(i);
            last_wdata  = 32'h5A5A_0000 + 32'(i);
         end
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cyc     = 0;
      reset_n = 1'b0;
      bus.ram_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 1024; i++) begin
         ram[i]    = 32'hC0DE_0000 | 32'(i);
         sb_mem[i] = 32'hC0DE_0000 | 32'(i);
      end
      last_addr  = '0;
      last_wdata = '0;

      test_reset();
      test_idle("after_reset");
      test_if_read();
      test_idle("after_if");
      test_priority();
      test_idle("after_prio");
      test_starvation();
      test_idle("after_starve");
      test_back_to_back();
      test_idle("after_sd_ld");
      test_misalign_wrap();
      test_idle("after_wrap");
      test_reset_midread();
      test_idle("after_reset_mid");
      test_idle("drain");
      @(negedge clock);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d reads outstanding expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared RAM (1024 words).
REQ-002 Parameter DATA_W, default 32, RAM word width.
REQ-003 Parameter STARVE_LIMIT, default 4, maximum number of consecutive MEM grants while IF is pending.
REQ-004 Port clock, input, 1: single clock, all state changes on its rising edge.
REQ-005 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port if_req, input, 1: instruction-fetch read request.
REQ-007 Port if_addr, input, 64: fetch byte address (PC).
REQ-008 Port if_gnt, output, 1: fetch request accepted this cycle.
REQ-009 Port if_rvalid, output, 1: fetch read data valid.
REQ-010 Port if_rdata, output, DATA_W: fetch read data.
REQ-011 Port mem_req, input, 1: LD/SD data access request.
REQ-012 Port mem_we, input, 1: 1 = store (SD), 0 = load (LD).
REQ-013 Port mem_addr, input, 64: data byte address (EX/MEM ALU result).
REQ-014 Port mem_wdata, input, DATA_W: store data.
REQ-015 Port mem_gnt, output, 1: data request accepted this cycle.
REQ-016 Port mem_rvalid, output, 1: load data valid.
REQ-017 Port mem_rdata, output, DATA_W: load data.
REQ-018 Port mem_misalign, output, 1: granted data access has mem_addr[1:0] != 0.
REQ-019 Ports ram_en / ram_we (1 each), ram_addr (ADDR_W), ram_wdata (DATA_W): outputs to the single-port RAM.
REQ-020 Port ram_rdata, input, DATA_W: RAM read data, valid exactly 1 cycle after ram_en && !ram_we.
REQ-021 Ports stall_if / stall_mem, outputs, 1 each: requester pending but not granted.

Function
REQ-022 At most one grant per cycle; if_gnt and mem_gnt are combinational from requests and registered state, never both 1.
REQ-023 Priority: mem_req wins over if_req, except when starve_cnt == STARVE_LIMIT and if_req == 1, in which case IF wins.
REQ-024 starve_cnt increments on each cycle with mem_gnt && if_req, saturates at STARVE_LIMIT, and clears on if_gnt or when if_req == 0.
REQ-025 On a grant: ram_en = 1, ram_addr = granted addr[ADDR_W+1:2] (upper bits truncated, wrap-around); ram_we = mem_we for MEM, 0 for IF.
REQ-026 On a MEM store grant: ram_wdata = mem_wdata; no rvalid is generated.
REQ-027 The FSM register rd_owner takes states NONE/IF/MEM, loaded each cycle with the owner of a read grant (NONE if no read grant).
REQ-028 if_rvalid = (rd_owner == IF); mem_rvalid = (rd_owner == MEM); read latency is exactly 1 cycle after the grant.
REQ-029 if_rdata and mem_rdata both equal ram_rdata; they are meaningful only while the matching rvalid is 1.
REQ-030 stall_if = if_req && !if_gnt; stall_mem = mem_req && !mem_gnt.
REQ-031 mem_misalign = mem_gnt && (mem_addr[1:0] != 0); the access proceeds with the low bits ignored.
REQ-032 With no requests: ram_en = 0, ram_we = 0, and ram_addr / ram_wdata hold their last values.
REQ-033 Back-to-back grants are allowed every cycle; a store followed by a load to the same word returns the stored data (RAM write-first not required, sequencing guarantees it).

Reset
REQ-034 reset_n low asynchronously forces rd_owner = NONE and starve_cnt = 0.
REQ-035 During reset: all grants, rvalids, ram_en, ram_we and mem_misalign = 0; ram_addr, ram_wdata, if_rdata and mem_rdata = 0.
REQ-036 A read granted in the cycle reset asserts produces no rvalid after reset deasserts.

Structure
REQ-037 A shared package holds ADDR_W/DATA_W defaults, the rd_owner enum (NONE/IF/MEM) and the LD/SD/NOP opcode constants.
REQ-038 The starvation counter is a sub-module named arb_starve_counter; the rest of the block is flat.

Verification
REQ-039 if_req = 1 alone, if_addr = 0x8 -> if_gnt = 1, ram_addr = 2; next cycle if_rvalid = 1 with if_rdata = RAM[2].
REQ-040 if_req and mem_req both 1 (LD, addr 0x10) -> mem_gnt = 1, stall_if = 1, ram_addr = 4; next cycle mem_rvalid = 1.
REQ-041 Both requests held 6 cycles -> MEM granted cycles 1-4, IF granted cycle 5, MEM granted cycle 6.
REQ-042 SD addr 0x20 data 0xA5 followed by LD addr 0x20 -> ram_we = 1 then 0; mem_rdata = 0xA5 one cycle after the LD grant.
REQ-043 LD addr 0x13 -> mem_misalign = 1, ram_addr = 4; LD addr 0x1000 -> ram_addr = 0 (wrap-around).
REQ-044 reset_n driven low in the same cycle as a read grant -> outputs clear immediately; no rvalid after release.
